led_ctrl: RTL and testbench

- Parametrised LED output peripheral on the bus bridge; successor to the single-register LED latch.
- Adds readback, atomic SET/CLR, per-LED blink enable, a global PWM brightness duty and a programmable tick prescaler.
- Sits behind the bridge decoder (bridge selects the block; this block decodes word offsets only) and drives `led_2soc` to the board.

---
 rtl/led_ctrl_pkg.sv | 18 +
 rtl/led_ctrl_if.sv | 21 ++
 rtl/led_tick_gen.sv | 65 ++++++
 rtl/led_ctrl.sv | 118 +++++++++++
 tb/tb_led_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared register offsets and reset constants for the LED output peripheral.
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    LED_OFF_VAL        = 3'd0,
    LED_OFF_BLINK_EN   = 3'd1,
    LED_OFF_DUTY       = 3'd2,
    LED_OFF_BLINK_HALF = 3'd3,
    LED_OFF_PRESC      = 3'd4,
    LED_OFF_SET        = 3'd5,
    LED_OFF_CLR        = 3'd6,
    LED_OFF_STATUS     = 3'd7
  } led_off_e;

  // Wide enough for the largest PWM width; the top keeps only its low PWM_BITS.
  localparam logic [15:0] LED_DUTY_RST = 16'hFFFF;

endpackage

// File: rtl/led_ctrl_if.sv
// Bridge-side register bus of the LED peripheral: word offset decode, single-cycle writes.
interface led_ctrl_if;
  logic [31:0] addr_from_bg;
  logic        we_from_bg;
  logic [31:0] wdata_from_bg;
  logic [31:0] rdata_2bg;

  modport master (
    output addr_from_bg,
    output we_from_bg,
    output wdata_from_bg,
    input  rdata_2bg
  );

  modport slave (
    input  addr_from_bg,
    input  we_from_bg,
    input  wdata_from_bg,
    output rdata_2bg
  );
endinterface

// File: rtl/led_tick_gen.sv
// Tick prescaler plus blink half-period counter; produces the shared blink phase.
module led_tick_gen #(
  parameter int PRESC_BITS = 16,
  parameter int BLINK_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PRESC_BITS-1:0] presc,
  input  logic                  presc_wr,
  input  logic [BLINK_BITS-1:0] blink_half,
  input  logic                  blink_wr,
  output logic                  tick,
  output logic                  blink_phase
);

  logic [PRESC_BITS-1:0] presc_cnt_reg, presc_cnt_next;
  logic [BLINK_BITS-1:0] blink_cnt_reg, blink_cnt_next;
  logic                  phase_reg, phase_next;
  logic                  presc_wrap;

  assign presc_wrap = (presc_cnt_reg == presc);
  // Reprogramming the prescaler restarts the period and swallows this cycle's tick.
  assign tick = presc_wrap && !presc_wr;

  always_comb begin
    presc_cnt_next = presc_cnt_reg + PRESC_BITS'(1);
    if (presc_wr || presc_wrap) begin
      presc_cnt_next = '0;
    end
  end

  always_comb begin
    blink_cnt_next = blink_cnt_reg;
    phase_next     = phase_reg;
    if (blink_wr) begin
      blink_cnt_next = '0;
      phase_next     = 1'b1;
    end else if (tick) begin
      if (blink_half == '0) begin
        blink_cnt_next = '0;
        phase_next     = 1'b1;
      end else if (blink_cnt_reg == blink_half - BLINK_BITS'(1)) begin
        blink_cnt_next = '0;
        phase_next     = ~phase_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + BLINK_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt_reg <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b1;
    end else begin
      presc_cnt_reg <= presc_cnt_next;
      blink_cnt_reg <= blink_cnt_next;
      phase_reg     <= phase_next;
    end
  end

  assign blink_phase = phase_reg;

endmodule

// File: rtl/led_ctrl.sv
// LED output peripheral: register file with SET/CLR, per-LED blink gating and
// a global PWM brightness, all combined into a registered LED drive.
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int NUM_LED    = 24,
  parameter int PWM_BITS   = 8,
  parameter int PRESC_BITS = 16,
  parameter int BLINK_BITS = 8
) (
  input  logic               clk_from_bg,
  input  logic               rst_n_from_bg,
  led_ctrl_if.slave          bus,
  output logic [NUM_LED-1:0] led_2soc
);

  led_off_e off;
  logic     we;
  assign off = led_off_e'(bus.addr_from_bg[4:2]);
  assign we  = bus.we_from_bg;

  logic [NUM_LED-1:0]    led_val_reg, led_val_next;
  logic [NUM_LED-1:0]    blink_en_reg;
  logic [PWM_BITS-1:0]   duty_reg;
  logic [BLINK_BITS-1:0] blink_half_reg;
  logic [PRESC_BITS-1:0] presc_reg;
  logic [PWM_BITS-1:0]   pwm_cnt_reg;
  logic [NUM_LED-1:0]    led_out_reg, led_out_next;
  logic [31:0]           rdata_reg, rdata_next;
  logic                  presc_wr, blink_wr, tick, blink_phase, pwm_on;

  assign presc_wr = we && (off == LED_OFF_PRESC);
  assign blink_wr = we && (off == LED_OFF_BLINK_HALF);

  // All three LED_VAL write flavours share one next-state path.
  always_comb begin
    led_val_next = led_val_reg;
    if (we) begin
      case (off)
        LED_OFF_VAL: led_val_next = bus.wdata_from_bg[NUM_LED-1:0];
        LED_OFF_SET: led_val_next = led_val_reg | bus.wdata_from_bg[NUM_LED-1:0];
        LED_OFF_CLR: led_val_next = led_val_reg & ~bus.wdata_from_bg[NUM_LED-1:0];
        default:     led_val_next = led_val_reg;
      endcase
    end
  end

  always_ff @(posedge clk_from_bg or negedge rst_n_from_bg) begin
    if (!rst_n_from_bg) begin
      led_val_reg    <= '0;
      blink_en_reg   <= '0;
      duty_reg       <= LED_DUTY_RST[PWM_BITS-1:0];
      blink_half_reg <= '0;
      presc_reg      <= '0;
    end else begin
      led_val_reg <= led_val_next;
      if (we && off == LED_OFF_BLINK_EN) blink_en_reg <= bus.wdata_from_bg[NUM_LED-1:0];
      if (we && off == LED_OFF_DUTY) duty_reg <= bus.wdata_from_bg[PWM_BITS-1:0];
      if (blink_wr) blink_half_reg <= bus.wdata_from_bg[BLINK_BITS-1:0];
      if (presc_wr) presc_reg <= bus.wdata_from_bg[PRESC_BITS-1:0];
    end
  end

  led_tick_gen #(
    .PRESC_BITS(PRESC_BITS),
    .BLINK_BITS(BLINK_BITS)
  ) u_tick_gen (
    .clk        (clk_from_bg),
    .rst_n      (rst_n_from_bg),
    .presc      (presc_reg),
    .presc_wr   (presc_wr),
    .blink_half (blink_half_reg),
    .blink_wr   (blink_wr),
    .tick       (tick),
    .blink_phase(blink_phase)
  );

  // Full-scale duty bypasses the compare so all-ones means truly always on.
  assign pwm_on = (&duty_reg) || (pwm_cnt_reg < duty_reg);

  generate
    for (genvar gi = 0; gi < NUM_LED; gi++) begin : g_led
      assign led_out_next[gi] = led_val_reg[gi] & pwm_on & (~blink_en_reg[gi] | blink_phase);
    end
  endgenerate

  always_comb begin
    rdata_next = '0;
    case (off)
      LED_OFF_VAL:        rdata_next = 32'(led_val_reg);
      LED_OFF_BLINK_EN:   rdata_next = 32'(blink_en_reg);
      LED_OFF_DUTY:       rdata_next = 32'(duty_reg);
      LED_OFF_BLINK_HALF: rdata_next = 32'(blink_half_reg);
      LED_OFF_PRESC:      rdata_next = 32'(presc_reg);
      LED_OFF_STATUS:     rdata_next = 32'(led_out_reg) | (32'(blink_phase) << NUM_LED);
      default:            rdata_next = '0;
    endcase
  end

  always_ff @(posedge clk_from_bg or negedge rst_n_from_bg) begin
    if (!rst_n_from_bg) begin
      pwm_cnt_reg <= '0;
      led_out_reg <= '0;
      rdata_reg   <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
      led_out_reg <= led_out_next;
      rdata_reg   <= rdata_next;
    end
  end

  assign led_2soc      = led_out_reg;
  assign bus.rdata_2bg = rdata_reg;

  logic unused_bits;
  assign unused_bits = ^{bus.addr_from_bg[31:5], bus.addr_from_bg[1:0], bus.wdata_from_bg, tick};

endmodule

// File: tb/tb_led_ctrl.sv
// Directed + randomised bench for led_ctrl against a tick-counting reference model.
module tb_led_ctrl;
  import led_ctrl_pkg::*;

  localparam int          NL    = 24;
  localparam int          MAXE  = 16384;
  localparam logic [31:0] LMASK = 32'h00FF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NL-1:0] led;

  led_ctrl_if bus();

  led_ctrl #(.NUM_LED(NL), .PWM_BITS(8), .PRESC_BITS(16), .BLINK_BITS(8)) dut (
    .clk_from_bg  (clk),
    .rst_n_from_bg(rst_n),
    .bus          (bus),
    .led_2soc     (led)
  );

  always #5 clk = ~clk;

  // Edge index since the last reset release; state k is what the DUT holds after edge k.
  int e;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_new[8], m_old[8];
  int          m_we[8];
  int          cum[MAXE];   // ticks seen in cycles 0..k-1
  bit          ph[MAXE];    // blink phase held in state k

  function automatic logic [31:0] width_mask(int r);
    case (r)
      0, 1:    return LMASK;
      2, 3:    return 32'h0000_00FF;
      4:       return 32'h0000_FFFF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] reg_at(int r, int j);
    return (j >= m_we[r]) ? m_new[r] : m_old[r];
  endfunction

  function automatic logic [31:0] exp_led(int k);
    int          j;
    logic [31:0] duty;
    if (k <= 0) return 32'h0;
    j    = k - 1;
    duty = reg_at(2, j);
    if (!(duty == 32'hFF || (j % 256) < int'(duty))) return 32'h0;
    return reg_at(0, j) & (ph[j] ? LMASK : (~reg_at(1, j) & LMASK));
  endfunction

  function automatic logic [31:0] exp_rd(int off, int j);
    case (off)
      0, 1, 2, 3, 4: return reg_at(off, j);
      7:             return exp_led(j) | (32'(ph[j]) << NL);
      default:       return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 8; r++) begin
      m_new[r] = 32'h0;
      m_old[r] = 32'h0;
      m_we[r]  = 0;
    end
    m_new[2] = 32'hFF;
    m_old[2] = 32'hFF;
    cum[0]   = 0;
    ph[0]    = 1'b1;
  endfunction

  function automatic void apply_write(int off, logic [31:0] d, int k);
    int          r;
    logic [31:0] cur;
    if (off == 7) return;
    r   = (off >= 5) ? 0 : off;
    cur = reg_at(r, k - 1);
    m_old[r] = cur;
    if (off == 5)      m_new[r] = cur | (d & LMASK);
    else if (off == 6) m_new[r] = cur & ~d & LMASK;
    else               m_new[r] = d & width_mask(r);
    m_we[r] = k;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at edge %0d", tag, got, want, e);
    end
  endtask

  // One clock: advance the model by the elapsed cycle, then compare LEDs and read data.
  task automatic step(bit wrote, int off, logic [31:0] d);
    int k, j, p, h, b, cur_off;
    bit t;
    cur_off = int'(bus.addr_from_bg[4:2]);
    @(posedge clk);
    #1;
    k = e;
    j = k - 1;
    if (k >= MAXE) begin
      $display("FAIL edge_budget: observed %0d expected below %0d", k, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    p = int'(reg_at(4, j));
    t = !(wrote && off == 4) && (((j - m_we[4]) % (p + 1)) == p);
    cum[k] = cum[j] + int'(t);
    if (wrote) apply_write(off, d, k);
    h = int'(reg_at(3, k));
    b = m_we[3];
    ph[k] = (h == 0) ? 1'b1 : ((((cum[k] - cum[b]) / h) % 2) == 0);
    chk("led", 32'(led), exp_led(k));
    chk("rdata", bus.rdata_2bg, exp_rd(cur_off, j));
  endtask

  task automatic wr(int off, logic [31:0] d);
    bus.addr_from_bg  = 32'(off) << 2;
    bus.we_from_bg    = 1'b1;
    bus.wdata_from_bg = d;
    step(1'b1, off, d);
    bus.we_from_bg = 1'b0;
    $display("wr off=%0d data=%h edge=%0d", off, d, e);
  endtask

  task automatic rd(int off);
    bus.addr_from_bg = 32'(off) << 2;
    bus.we_from_bg   = 1'b0;
    step(1'b0, off, 32'h0);
    $display("rd off=%0d data=%h edge=%0d", off, bus.rdata_2bg, e);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 32'h0);
  endtask

  task automatic set_timing(int p, int h);
    wr(4, 32'(p));
    wr(3, 32'(h));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          cnt, n, b, hit;
    int          chg[$];
    logic        prev;
    logic [31:0] d;

    bus.addr_from_bg  = 32'h0;
    bus.we_from_bg    = 1'b0;
    bus.wdata_from_bg = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_rdata", bus.rdata_2bg, 32'h0);
    #3 rst_n = 1'b1;

    rd(2);
    chk("rst_duty", bus.rdata_2bg, 32'hFF);
    rd(7);
    chk("rst_phase", 32'(bus.rdata_2bg[NL]), 32'h1);

    // Write-to-pin latency and readback.
    wr(0, 32'h00A5A5);
    chk("lat_edge1", 32'(led), 32'h0);
    idle(1);
    chk("lat_edge2", 32'(led), 32'h00A5A5);
    rd(0);
    chk("rd_val", bus.rdata_2bg, 32'h00A5A5);

    // SET / CLR and write-only readback.
    wr(0, 32'h0000F0);
    wr(5, 32'h00000F);
    wr(6, 32'h000030);
    rd(0);
    chk("setclr", bus.rdata_2bg, 32'h0000CF);
    rd(5);
    chk("rd_wo", bus.rdata_2bg, 32'h0);
    bus.addr_from_bg = 32'h0;
    wr(0, 32'h123456);
    chk("rd_old_on_wr", bus.rdata_2bg, 32'h0000CF);
    wr(7, 32'hFFFF_FFFF);
    rd(0);
    chk("status_wr_ignored", bus.rdata_2bg, 32'h123456);

    // PWM duty cycle.
    wr(2, 32'h40);
    wr(0, 32'h1);
    idle(2);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      idle(1);
      cnt += int'(led[0]);
    end
    chk("pwm_64of256", 32'(cnt), 32'd64);
    wr(2, 32'h0);
    idle(2);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      idle(1);
      cnt += int'(led[0]);
    end
    chk("pwm_off", 32'(cnt), 32'd0);
    wr(2, 32'hFF);
    idle(2);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      idle(1);
      cnt += int'(led[0]);
    end
    chk("pwm_full", 32'(cnt), 32'd60);

    // Blink: PRESC=3, BLINK_HALF=2 -> bit 0 toggles every 8 cycles.
    set_timing(3, 2);
    wr(1, 32'h1);
    wr(0, 32'h3);
    idle(2);
    prev = led[0];
    for (int i = 0; i < 80; i++) begin
      rd(7);
      chk("steady_bit1", 32'(led[1]), 32'h1);
      if (led[0] !== prev) chg.push_back(e);
      prev = led[0];
    end
    chk("blink_changes", 32'(chg.size() >= 8), 32'h1);
    for (int i = 1; i < chg.size(); i++) chk("blink_period", 32'(chg[i] - chg[i-1]), 32'd8);

    // BLINK_HALF rewrite on a tick cycle while the phase is low.
    n = 0;
    while (!(ph[e] == 1'b0 && ((e - m_we[4]) % 4) == 3) && n < 40) begin
      rd(7);
      n++;
    end
    chk("find_tick", 32'(n < 40), 32'h1);
    wr(3, 32'h5);
    b = e;
    rd(7);
    chk("bh_phase1", 32'(bus.rdata_2bg[NL]), 32'h1);
    chk("bh_led_on", 32'(led[0]), 32'h1);
    hit = -1;
    for (int i = 0; i < 60 && hit < 0; i++) begin
      rd(7);
      if (led[0] == 1'b0) hit = e;
    end
    chk("bh_first_toggle", 32'(hit), 32'(b + 21));

    // Randomised register traffic.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 4))
        0: set_timing(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
        1: begin
          case ($urandom_range(0, 3))
            0:       d = 32'h0;
            1:       d = 32'hFF;
            default: d = $urandom;
          endcase
          wr(2, d);
        end
        2: wr(int'($urandom_range(0, 1)) + (($urandom_range(0, 1) == 1) ? 5 : 0), $urandom);
        default: rd(int'($urandom_range(0, 7)));
      endcase
      for (int i = int'($urandom_range(0, 20)); i > 0; i--) rd(int'($urandom_range(0, 7)));
    end

    // Asynchronous reset mid-operation.
    wr(0, 32'hFFFFFF);
    wr(1, 32'h0);
    wr(2, 32'hFF);
    idle(2);
    chk("pre_rst_led", 32'(led), 32'hFFFFFF);
    rd(0);
    chk("pre_rst_rdata", bus.rdata_2bg, 32'hFFFFFF);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(led), 32'h0);
    chk("async_rst_rdata", bus.rdata_2bg, 32'h0);
    #1 rst_n = 1'b1;
    model_reset();
    rd(2);
    chk("post_rst_duty", bus.rdata_2bg, 32'hFF);
    rd(7);
    chk("post_rst_phase", 32'(bus.rdata_2bg[NL]), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
